sub_bytes_arb: RTL and testbench

Arbiter and response tracker sharing a single `sub_bytes` instance between the round datapath (128-bit state) and the key-expansion unit (32-bit SubWord). Each cycle it grants at most one requester and drives that requester's data into the shared S-box array. It tags the operation through a latency-matched pipeline and steers the substituted result back to its owner with a one-cycle valid pulse. This removes the need for a second 16-S-box array for key expansion.

---
 rtl/aes_pkg.sv | 25 ++
 rtl/sb_tag_pipe.sv | 54 +++++
 rtl/sub_bytes_arb.sv | 115 +++++++++++
 tb/tb_sub_bytes_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: datapath widths, the owner tag that travels with each
// S-box operation, and a helper that places a 32-bit word in a 128-bit lane.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_WORD_W  = 32;

  // Which requester an in-flight S-box operation belongs to.
  typedef enum logic {
    OWN_RND = 1'b0,
    OWN_KEY = 1'b1
  } sb_owner_t;

  // One stage of the latency-matched tag pipeline.
  typedef struct packed {
    logic      vld;
    sb_owner_t owner;
  } sb_tag_t;

  // Zero-extend a SubWord operand into the low lanes of the shared S-box array.
  function automatic logic [AES_STATE_W-1:0] widen_word(input logic [AES_WORD_W-1:0] w);
    return {{(AES_STATE_W - AES_WORD_W){1'b0}}, w};
  endfunction

endpackage

// File: rtl/sb_tag_pipe.sv
// LAT-deep shift register of {valid, owner} tags, kept in step with the shared
// sub_bytes latency so that each result can be matched to its requester.
// Shifts every cycle with no stall; asynchronous active-low clear. LAT must be >= 1.
module sb_tag_pipe
  import aes_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_vld,
  input  sb_owner_t in_owner,
  output logic      out_vld,
  output sb_owner_t out_owner,
  output logic      any_vld
);

  sb_tag_t tag_reg [LAT];

  // Stage 0 captures the current grant (or a bubble) every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_reg[0] <= '{vld: 1'b0, owner: OWN_RND};
    end else begin
      tag_reg[0] <= '{vld: in_vld, owner: in_owner};
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < LAT; gi++) begin : g_stage
      // Each later stage copies its predecessor; a reset drops everything in flight.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_reg[gi] <= '{vld: 1'b0, owner: OWN_RND};
        end else begin
          tag_reg[gi] <= tag_reg[gi-1];
        end
      end
    end
  endgenerate

  // Busy indication: any stage still carries a live operation.
  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      any_vld = any_vld | tag_reg[i].vld;
    end
  end

  assign out_vld   = tag_reg[LAT-1].vld;
  assign out_owner = tag_reg[LAT-1].owner;

endmodule

// File: rtl/sub_bytes_arb.sv
// Arbiter and response tracker sharing one sub_bytes array between the round
// datapath (128-bit state) and key expansion (32-bit SubWord).
// Optional feature macro: SUB_BYTES_ARB_RR_EN selects round-robin arbitration;
// without it key expansion has fixed priority over the round datapath.
module sub_bytes_arb
  import aes_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rnd_req,
  input  logic [AES_STATE_W-1:0] rnd_din,
  output logic                   rnd_gnt,
  output logic                   rnd_vld,
  output logic [AES_STATE_W-1:0] rnd_dout,
  input  logic                   key_req,
  input  logic [AES_WORD_W-1:0]  key_din,
  output logic                   key_gnt,
  output logic                   key_vld,
  output logic [AES_WORD_W-1:0]  key_dout,
  output logic [AES_STATE_W-1:0] sb_din,
  input  logic [AES_STATE_W-1:0] sb_dout,
  output logic                   busy
);

  logic      both_req;
  sb_owner_t winner;
  logic      gnt_any;
  sb_owner_t gnt_owner;
  logic      last_vld;
  sb_owner_t last_owner;

  // Contention only counts outside reset, since requests are ignored then.
  assign both_req = rst_n & rnd_req & key_req;

`ifdef SUB_BYTES_ARB_RR_EN
  // Owner that wins the next contended cycle; flips each time it is used so
  // that continuous contention alternates grants.
  sb_owner_t next_pref_reg;

  // Pointer starts at "key next" and advances only on contended cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_pref_reg <= OWN_KEY;
    end else if (both_req) begin
      next_pref_reg <= (next_pref_reg == OWN_KEY) ? OWN_RND : OWN_KEY;
    end
  end

  assign winner = next_pref_reg;
`else
  // Fixed priority: key expansion always wins a contended cycle.
  assign winner = OWN_KEY;
`endif

  // Combinational grant: a lone requester is granted at once, contention goes
  // to the winner, and nothing is granted while reset is asserted.
  always_comb begin
    rnd_gnt = 1'b0;
    key_gnt = 1'b0;
    if (rst_n) begin
      if (both_req) begin
        rnd_gnt = (winner == OWN_RND);
        key_gnt = (winner == OWN_KEY);
      end else begin
        rnd_gnt = rnd_req;
        key_gnt = key_req;
      end
    end
  end

  assign gnt_any   = rnd_gnt | key_gnt;
  assign gnt_owner = key_gnt ? OWN_KEY : OWN_RND;

  // Operand mux into the shared S-box array; idle cycles present zeros.
  always_comb begin
    sb_din = '0;
    if (key_gnt) begin
      sb_din = widen_word(key_din);
    end else if (rnd_gnt) begin
      sb_din = rnd_din;
    end
  end

  sb_tag_pipe #(
    .LAT (LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (gnt_any),
    .in_owner  (gnt_owner),
    .out_vld   (last_vld),
    .out_owner (last_owner),
    .any_vld   (busy)
  );

  // Steer the returning S-box result to its owner; data is zero when not valid.
  always_comb begin
    rnd_vld  = 1'b0;
    key_vld  = 1'b0;
    rnd_dout = '0;
    key_dout = '0;
    if (last_vld) begin
      if (last_owner == OWN_KEY) begin
        key_vld  = 1'b1;
        key_dout = sb_dout[AES_WORD_W-1:0];
      end else begin
        rnd_vld  = 1'b1;
        rnd_dout = sb_dout;
      end
    end
  end

endmodule

// File: tb/tb_sub_bytes_arb.sv
// Testbench for sub_bytes_arb: one instance with LAT=1 driven from a vector
// table, one with LAT=3 driven by hand-written multi-cycle sequences. Each
// instance is paired with a behavioural S-box array of matching latency.
module tb_sub_bytes_arb;

`ifdef SUB_BYTES_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [127:0] Z128 = 128'h0;
  localparam logic [127:0] A63  = {16{8'h63}};
  localparam logic [127:0] AED  = {16{8'hED}};
  localparam logic [127:0] A53  = {16{8'h53}};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // LAT=1 instance signals
  logic         r1_req, r1_gnt, r1_vld, k1_req, k1_gnt, k1_vld, busy1;
  logic [127:0] r1_din, r1_dout, sb_din1, sb_dout1;
  logic [31:0]  k1_din, k1_dout;
  // LAT=3 instance signals
  logic         r3_req, r3_gnt, r3_vld, k3_req, k3_gnt, k3_vld, busy3;
  logic [127:0] r3_din, r3_dout, sb_din3, sb_dout3;
  logic [31:0]  k3_din, k3_dout;

  sub_bytes_arb #(.LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .rnd_req(r1_req), .rnd_din(r1_din), .rnd_gnt(r1_gnt), .rnd_vld(r1_vld), .rnd_dout(r1_dout),
    .key_req(k1_req), .key_din(k1_din), .key_gnt(k1_gnt), .key_vld(k1_vld), .key_dout(k1_dout),
    .sb_din(sb_din1), .sb_dout(sb_dout1), .busy(busy1)
  );

  sub_bytes_arb #(.LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .rnd_req(r3_req), .rnd_din(r3_din), .rnd_gnt(r3_gnt), .rnd_vld(r3_vld), .rnd_dout(r3_dout),
    .key_req(k3_req), .key_din(k3_din), .key_gnt(k3_gnt), .key_vld(k3_vld), .key_dout(k3_dout),
    .sb_din(sb_din3), .sb_dout(sb_dout3), .busy(busy3)
  );

  // ---------------- behavioural S-box (GF(2^8) inverse + affine) ----------------
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, xb;
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (xb != 8'h00 && gf_mul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [127:0] sbox128(input logic [127:0] v);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox_tab[v[i*8 +: 8]];
    return r;
  endfunction

  logic [127:0] d3_a, d3_b;
  always @(posedge clk) begin
    sb_dout1 <= sbox128(sb_din1);
    d3_a     <= sbox128(sb_din3);
    d3_b     <= d3_a;
    sb_dout3 <= d3_b;
  end

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         rr;
    logic [127:0] rd;
    logic         kr;
    logic [31:0]  kd;
    logic         e_rg;
    logic         e_kg;
    logic         e_rv;
    logic [127:0] e_rdo;
    logic         e_kv;
    logic [31:0]  e_kdo;
    logic         e_busy;
  } vec_t;

  vec_t tbl [13];

  // One cycle on the LAT=3 instance: check at the falling edge, then advance.
  task automatic cyc3(input string nm, input logic rg, input logic kg, input logic rv,
                      input logic [127:0] rdo, input logic kv, input logic [31:0] kdo,
                      input logic bz);
    @(negedge clk);
    chk({nm, " rnd_gnt"}, r3_gnt, rg);
    chk({nm, " key_gnt"}, k3_gnt, kg);
    chk({nm, " rnd_vld"}, r3_vld, rv);
    chk({nm, " rnd_dout"}, r3_dout, rdo);
    chk({nm, " key_vld"}, k3_vld, kv);
    chk({nm, " key_dout"}, k3_dout, kdo);
    chk({nm, " busy"}, busy3, bz);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic         kw, prev_r, prev_k;
    logic [127:0] exp_sb;

    // Table for the LAT=1 instance: expected values are for the same cycle.
    tbl[0] = '{1'b0, Z128, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, Z128, 1'b0, 32'h0,        1'b0};
    tbl[1] = '{1'b1, Z128, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, Z128, 1'b0, 32'h0,        1'b0};
    tbl[2] = '{1'b0, Z128, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, A63,  1'b0, 32'h0,        1'b1};
    tbl[3] = '{1'b0, Z128, 1'b1, 32'h0153FF00, 1'b0, 1'b1, 1'b0, Z128, 1'b0, 32'h0,        1'b0};
    tbl[4] = '{1'b0, Z128, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, Z128, 1'b1, 32'h7CED1663, 1'b1};
    // Six contended cycles: RR alternates key, round, ...; fixed priority is all key.
    prev_r = 1'b0;
    prev_k = 1'b0;
    for (int k = 0; k < 6; k++) begin
      kw = RR ? (k % 2 == 0) : 1'b1;
      tbl[5+k] = '{1'b1, A53, 1'b1, 32'h0, ~kw, kw,
                   prev_r, prev_r ? AED : Z128, prev_k, prev_k ? 32'h63636363 : 32'h0, (k > 0)};
      prev_r = ~kw;
      prev_k = kw;
    end
    tbl[11] = '{1'b0, Z128, 1'b0, 32'h0, 1'b0, 1'b0,
                prev_r, prev_r ? AED : Z128, prev_k, prev_k ? 32'h63636363 : 32'h0, 1'b1};
    tbl[12] = '{1'b0, Z128, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, Z128, 1'b0, 32'h0, 1'b0};

    // Reset with requests asserted: everything must read zero.
    rst_n  = 1'b0;
    r1_req = 1'b1; r1_din = A53; k1_req = 1'b1; k1_din = 32'hDEADBEEF;
    r3_req = 1'b1; r3_din = A53; k3_req = 1'b1; k3_din = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rnd_gnt", r1_gnt, 1'b0);
    chk("reset key_gnt", k1_gnt, 1'b0);
    chk("reset sb_din", sb_din1, Z128);
    chk("reset rnd_vld", r1_vld, 1'b0);
    chk("reset key_vld", k1_vld, 1'b0);
    chk("reset rnd_dout", r1_dout, Z128);
    chk("reset key_dout", k1_dout, 32'h0);
    chk("reset busy", busy1, 1'b0);
    chk("reset busy3", busy3, 1'b0);
    chk("reset sb_din3", sb_din3, Z128);
    @(posedge clk);
    #1;
    r1_req = 1'b0; k1_req = 1'b0; r3_req = 1'b0; k3_req = 1'b0;
    r1_din = Z128; k1_din = 32'h0; r3_din = Z128; k3_din = 32'h0;
    rst_n  = 1'b1;

    // Table-driven run on the LAT=1 instance.
    for (int i = 0; i < 13; i++) begin
      r1_req = tbl[i].rr; r1_din = tbl[i].rd; k1_req = tbl[i].kr; k1_din = tbl[i].kd;
      exp_sb = tbl[i].e_kg ? {96'h0, tbl[i].kd} : (tbl[i].e_rg ? tbl[i].rd : Z128);
      @(negedge clk);
      chk($sformatf("v%0d rnd_gnt", i), r1_gnt, tbl[i].e_rg);
      chk($sformatf("v%0d key_gnt", i), k1_gnt, tbl[i].e_kg);
      chk($sformatf("v%0d sb_din", i), sb_din1, exp_sb);
      chk($sformatf("v%0d rnd_vld", i), r1_vld, tbl[i].e_rv);
      chk($sformatf("v%0d rnd_dout", i), r1_dout, tbl[i].e_rdo);
      chk($sformatf("v%0d key_vld", i), k1_vld, tbl[i].e_kv);
      chk($sformatf("v%0d key_dout", i), k1_dout, tbl[i].e_kdo);
      chk($sformatf("v%0d busy", i), busy1, tbl[i].e_busy);
      @(posedge clk);
      #1;
    end
    r1_req = 1'b0; k1_req = 1'b0;

    // LAT=3: back-to-back round, key, round; each request dropped after its grant.
    r3_req = 1'b1; r3_din = Z128;
    cyc3("l3 c0", 1'b1, 1'b0, 1'b0, Z128, 1'b0, 32'h0, 1'b0);
    r3_req = 1'b0; k3_req = 1'b1; k3_din = 32'h0153FF00;
    cyc3("l3 c1", 1'b0, 1'b1, 1'b0, Z128, 1'b0, 32'h0, 1'b1);
    k3_req = 1'b0; r3_req = 1'b1; r3_din = A53;
    cyc3("l3 c2", 1'b1, 1'b0, 1'b0, Z128, 1'b0, 32'h0, 1'b1);
    r3_req = 1'b0; r3_din = Z128; k3_din = 32'h0;
    cyc3("l3 c3", 1'b0, 1'b0, 1'b1, A63,  1'b0, 32'h0, 1'b1);
    cyc3("l3 c4", 1'b0, 1'b0, 1'b0, Z128, 1'b1, 32'h7CED1663, 1'b1);
    cyc3("l3 c5", 1'b0, 1'b0, 1'b1, AED,  1'b0, 32'h0, 1'b1);
    cyc3("l3 c6", 1'b0, 1'b0, 1'b0, Z128, 1'b0, 32'h0, 1'b0);

    // LAT=3: reset one cycle after a grant drops the in-flight operation.
    r3_req = 1'b1; r3_din = A53;
    cyc3("rst c0", 1'b1, 1'b0, 1'b0, Z128, 1'b0, 32'h0, 1'b0);
    rst_n  = 1'b0;
    k3_req = 1'b1; k3_din = 32'h12345678;
    cyc3("rst c1", 1'b0, 1'b0, 1'b0, Z128, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst sb_din3", sb_din3, Z128);
    chk("rst rnd_gnt1", r1_gnt, 1'b0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    r3_req = 1'b0; k3_req = 1'b0; r3_din = Z128; k3_din = 32'h0;
    for (int c = 0; c < 5; c++) begin
      cyc3($sformatf("post rst c%0d", c), 1'b0, 1'b0, 1'b0, Z128, 1'b0, 32'h0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
